// File: rtl/shift_count_reg_if.sv
// Stimulus/response bundle for shift_count_reg: control and data in, register state out.
// The driver side uses the master modport; the register block uses slave.
interface shift_count_reg_if #(
  parameter int WIDTH = 4,
  parameter int WRAPW = 8
);
  logic             ENB;
  logic             DIR;
  logic             S_IN;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             S_OUT;
  logic [WRAPW-1:0] WRAP_CNT;

  modport master (
    output ENB, DIR, S_IN, MODO, D,
    input  Q, S_OUT, WRAP_CNT
  );

  modport slave (
    input  ENB, DIR, S_IN, MODO, D,
    output Q, S_OUT, WRAP_CNT
  );
endinterface

// File: rtl/shift_count_reg.sv
// Four-mode register: shift, rotate, parallel load and (optionally) up/down count.
// Define SHIFT_COUNT_REG_COUNT_MODE_EN to build the counter and its saturating wrap counter.
module shift_count_reg #(
  parameter int WIDTH = 4,
  parameter int WRAPW = 8
) (
  input  logic             CLK,
  input  logic             RST,
  shift_count_reg_if.slave bus
);

  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;

  logic [WIDTH-1:0] q;
  logic             s_out;
  logic [WRAPW-1:0] wrap_cnt;

`ifdef SHIFT_COUNT_REG_COUNT_MODE_EN
  localparam logic [1:0] MODE_COUNT = 2'b11;

  // An enabled count step wraps when leaving all-ones upward or zero downward.
  logic step_wraps;
  assign step_wraps = bus.ENB && (bus.MODO == MODE_COUNT) &&
                      (bus.DIR ? (q == '0) : (&q));
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      q     <= '0;
      s_out <= 1'b0;
    end else if (bus.ENB) begin
      case (bus.MODO)
        MODE_SHIFT: begin
          if (!bus.DIR) begin
            q     <= {q[WIDTH-2:0], bus.S_IN};
            s_out <= q[WIDTH-1];
          end else begin
            q     <= {bus.S_IN, q[WIDTH-1:1]};
            s_out <= q[0];
          end
        end
        MODE_ROTATE: begin
          if (!bus.DIR) begin
            q     <= {q[WIDTH-2:0], q[WIDTH-1]};
            s_out <= q[WIDTH-1];
          end else begin
            q     <= {q[0], q[WIDTH-1:1]};
            s_out <= q[0];
          end
        end
        MODE_LOAD: begin
          q     <= bus.D;
          s_out <= 1'b0;
        end
        default: begin
`ifdef SHIFT_COUNT_REG_COUNT_MODE_EN
          q     <= bus.DIR ? (q - WIDTH'(1)) : (q + WIDTH'(1));
          s_out <= step_wraps;
`endif
        end
      endcase
    end
  end

`ifdef SHIFT_COUNT_REG_COUNT_MODE_EN
  // Saturates at all-ones so a long-running count never appears to restart.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wrap_cnt <= '0;
    end else if (step_wraps && (wrap_cnt != '1)) begin
      wrap_cnt <= wrap_cnt + WRAPW'(1);
    end
  end
`else
  assign wrap_cnt = '0;
`endif

  assign bus.Q        = q;
  assign bus.S_OUT    = s_out;
  assign bus.WRAP_CNT = wrap_cnt;

endmodule

// File: tb/tb_shift_count_reg.sv
// Randomised and directed stimulus for shift_count_reg, checked by a queue-based scoreboard
// against an arithmetic reference model (honours SHIFT_COUNT_REG_COUNT_MODE_EN like the DUT).
module tb_shift_count_reg;

  localparam int WIDTH = 4;
  localparam int WRAPW = 2;
  localparam int QMOD  = 1 << WIDTH;
  localparam int QTOP  = 1 << (WIDTH - 1);
  localparam int WMAX  = (1 << WRAPW) - 1;

  typedef struct {
    int q;
    int s;
    int w;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  shift_count_reg_if #(.WIDTH(WIDTH), .WRAPW(WRAPW)) bus ();

  shift_count_reg #(.WIDTH(WIDTH), .WRAPW(WRAPW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_q = 0;
  int   m_s = 0;
  int   m_w = 0;

  // Drive one cycle of inputs away from the edge and push what the register must show after it.
  task automatic applyStimulus(input logic rst, input logic enb, input logic dir,
                               input logic s_in, input logic [1:0] modo, input int d);
    exp_t e;
    int   bit_out;
    @(negedge CLK);
    RST      = rst;
    bus.ENB  = enb;
    bus.DIR  = dir;
    bus.S_IN = s_in;
    bus.MODO = modo;
    bus.D    = WIDTH'(d);
    if (rst) begin
      m_q = 0;
      m_s = 0;
      m_w = 0;
    end else if (enb) begin
      case (modo)
        2'd0: begin
          bit_out = dir ? (m_q % 2) : (m_q / QTOP);
          m_q = dir ? (m_q / 2 + int'(s_in) * QTOP) : ((m_q * 2 + int'(s_in)) % QMOD);
          m_s = bit_out;
        end
        2'd1: begin
          bit_out = dir ? (m_q % 2) : (m_q / QTOP);
          m_q = dir ? (m_q / 2 + bit_out * QTOP) : ((m_q * 2 + bit_out) % QMOD);
          m_s = bit_out;
        end
        2'd2: begin
          m_q = d % QMOD;
          m_s = 0;
        end
        default: begin
`ifdef SHIFT_COUNT_REG_COUNT_MODE_EN
          bit_out = dir ? int'(m_q == 0) : int'(m_q == QMOD - 1);
          m_q = dir ? ((m_q + QMOD - 1) % QMOD) : ((m_q + 1) % QMOD);
          m_s = bit_out;
          if (bit_out == 1 && m_w < WMAX) m_w = m_w + 1;
`endif
        end
      endcase
    end
    e.q = m_q;
    e.s = m_s;
    e.w = m_w;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("[TB] FAIL %s at vector %0d: got %0h, expected %0h", name, vectors, act, exp);
    end
  endtask

  // Monitor: one registered result per edge, compared just after it settles.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        vectors++;
        checkOutput("Q", 32'(bus.Q), mon_e.q);
        checkOutput("S_OUT", 32'(bus.S_OUT), mon_e.s);
        checkOutput("WRAP_CNT", 32'(bus.WRAP_CNT), mon_e.w);
      end
    end
  end

  initial begin
    int waited;
    RST = 1'b1; bus.ENB = 1'b0; bus.DIR = 1'b0; bus.S_IN = 1'b0; bus.MODO = 2'b00; bus.D = '0;

    applyStimulus(1, 0, 0, 0, 2'd0, 0);
    // Reset mid-run beats an enabled count
    applyStimulus(0, 1, 0, 0, 2'd2, 4'b1010);
    applyStimulus(1, 1, 0, 0, 2'd3, 0);
    // Parallel load sweep
    for (int d = 0; d < QMOD; d++) applyStimulus(0, 1, d[0], ~d[1], 2'd2, d);
    // Shift both ways
    applyStimulus(0, 1, 0, 0, 2'd2, 4'b1001);
    applyStimulus(0, 1, 0, 0, 2'd0, 0);
    applyStimulus(0, 1, 1, 1, 2'd0, 0);
    // Rotate left four times, then hold
    applyStimulus(0, 1, 0, 0, 2'd2, 4'b1000);
    repeat (4) applyStimulus(0, 1, 0, 0, 2'd1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 2'(i), 4'b0110);
    applyStimulus(0, 1, 1, 0, 2'd1, 0);
    // Count up through a wrap, then down through one
    applyStimulus(0, 1, 0, 0, 2'd2, 4'b1110);
    repeat (3) applyStimulus(0, 1, 0, 0, 2'd3, 0);
    repeat (2) applyStimulus(0, 1, 1, 0, 2'd3, 0);
    // Drive the wrap counter into saturation
    repeat (5) begin
      applyStimulus(0, 1, 0, 0, 2'd2, 4'b1111);
      applyStimulus(0, 1, 0, 0, 2'd3, 0);
    end
    applyStimulus(0, 1, 0, 0, 2'd2, 4'b0101);
    repeat (2) applyStimulus(0, 1, 0, 0, 2'd3, 0);
    applyStimulus(0, 0, 0, 0, 2'd3, 0);
    applyStimulus(0, 1, 1, 0, 2'd3, 0);
    // Random traffic with occasional resets and idle cycles
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0),
                    1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, QMOD - 1));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge CLK);
      waited++;
    end
    #2;
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
